gate_chain_pipe: RTL and testbench
==================================

GATE_CHAIN_PIPE -- requirements
Module: gate_chain_pipe

Interface
REQ-001 Parameter N, default 4: number of chained inputs, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the delivered-result counter.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  N  gate inputs d[0]..d[N-1].
REQ-008 in_op  input  2  gate type for this beat: 00 NOR, 01 NAND, 10 XOR, 11 XNOR.
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_taps  output  N-1  intermediate results t[0]..t[N-2] (present only with GATE_CHAIN_TAPS_EN).
REQ-012 out_result  output  1  final chain result t[N-2].
REQ-013 out_count  output  CNT_W  number of results delivered.

Function
REQ-014 The chain SHALL compute t[0]=op(d[0],d[1]) and t[k]=op(d[k+1],t[k-1]) for k=1..N-2.
REQ-015 The pipeline SHALL have N-1 register stages, with stage k producing t[k].
REQ-016 in_op SHALL be captured with in_data and travel with it, so consecutive beats with different ops are independent.
REQ-017 Global advance = out_ready OR NOT out_valid.
REQ-018 in_ready SHALL equal advance (combinational); all stages shift together on advance, and empty slots travel as bubbles.
REQ-019 A beat is accepted only on in_valid AND in_ready; otherwise nothing is captured and upstream holds its data.
REQ-020 Latency SHALL be N-1 cycles from acceptance to out_valid when no stall occurs; throughput SHALL be one beat per cycle.
REQ-021 While out_valid=1 and out_ready=0, out_result, out_taps and out_valid SHALL hold stable.
REQ-022 out_count SHALL increment by 1 on each out_valid AND out_ready, wrapping from 2^CNT_W-1 to 0.
REQ-023 For N=2 there SHALL be a single stage, and out_taps[0] equals out_result.

Reset
REQ-024 While rst=1: all stage valids, out_valid, out_result, out_taps and out_count SHALL clear to 0, and in_ready SHALL be 0.
REQ-025 A reset asserted mid-operation SHALL discard all in-flight beats, none of which ever reaches the output.
REQ-026 In the first cycle after rst deasserts, in_ready SHALL be 1.

Configuration
REQ-027 Macro GATE_CHAIN_TAPS_EN defined: out_taps SHALL be present, carrying all registered intermediate results aligned with out_result.
REQ-028 GATE_CHAIN_TAPS_EN undefined: out_taps SHALL be absent; each stage SHALL carry only the running t value and the remaining inputs; out_result behaviour is unchanged.

Structure
REQ-029 Package gate_chain_pkg SHALL hold the op-code constants/enum and a function apply_op(op,a,b).
REQ-030 Sub-module gate_chain_stage SHALL implement one registered stage (valid, op, running t, remaining data, optional taps), instantiated N-1 times by generate.

Verification
REQ-031 N=4, NOR, in_data=4'b0000 -> after 3 cycles: out_taps=3'b101 (t2,t1,t0), out_result=1.
REQ-032 N=4, in_data=4'b1010, four back-to-back beats with ops NOR, NAND, XOR, XNOR -> on consecutive cycles 3..6, out_taps=010, 011, 011, 110 and out_result=0, 0, 0, 1; out_count ends at 4.
REQ-033 Pipeline full, out_ready=0 for 5 cycles -> in_ready=0, outputs stable; on release, 3 results leave in order with none lost or duplicated.
REQ-034 CNT_W=4, 17 transfers with out_ready=1 -> out_count=1.
REQ-035 Two beats accepted, then rst pulsed for 1 cycle at cycle 2 -> out_valid never asserts for them and out_count=0.
REQ-036 Macro undefined, N=4 NOR, in_data=4'b0000 -> out_result=1 after 3 cycles, and no out_taps port exists.

Source files
------------

// File: rtl/gate_chain_pkg.sv
// gate_chain_pkg: op-codes and the two-input gate function
// shared by every gate_chain_pipe stage.
package gate_chain_pkg;

  typedef enum logic [1:0] {
    OP_NOR  = 2'b00,
    OP_NAND = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  function automatic logic apply_op(
    input op_e  op,
    input logic a,
    input logic b
  );
    logic r;
    unique case (op)
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XOR:  r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_chain_if.sv
// gate_chain_if: valid/ready in and out channels of gate_chain_pipe.
// out_taps exists only when GATE_CHAIN_TAPS_EN is defined.
interface gate_chain_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  import gate_chain_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  op_e              in_op;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic [CNT_W-1:0] out_count;
`ifdef GATE_CHAIN_TAPS_EN
  logic [N-2:0]     out_taps;
`endif

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_count
`ifdef GATE_CHAIN_TAPS_EN
    , out_taps
`endif
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_result, out_count
`ifdef GATE_CHAIN_TAPS_EN
    , out_taps
`endif
  );

endinterface

// File: rtl/gate_chain_stage.sv
// gate_chain_stage: one register stage k of the gate chain.
// Carries taps only when GATE_CHAIN_TAPS_EN is defined.
module gate_chain_stage
  import gate_chain_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 0,
  parameter int RW = N - 1 - K
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  input  logic                        v_i,
  input  op_e                         op_i,
  input  logic                        t_i,
  input  logic [RW-1:0]               rem_i,
`ifdef GATE_CHAIN_TAPS_EN
  input  logic [N-2:0]                taps_i,
  output logic [N-2:0]                taps_o,
`endif
  output logic                        v_o,
  output op_e                         op_o,
  output logic                        t_o,
  output logic [(RW>1?RW-2:0):0]      rem_o
);

  localparam int TW = N - 1;

  logic ld;
  logic t_new;
  logic v_q, v_d;
  logic t_q, t_d;
  op_e  op_q, op_d;

  // next state: shift on advance, payload only for real beats
  always_comb begin
    ld    = adv && v_i;
    t_new = apply_op(op_i, rem_i[0], t_i);
    v_d   = v_q;
    op_d  = op_q;
    t_d   = t_q;
    if (adv) v_d = v_i;
    if (ld) begin
      op_d = op_i;
      t_d  = t_new;
    end
  end

  // stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= 1'b0;
      op_q <= OP_NOR;
      t_q  <= 1'b0;
    end else begin
      v_q  <= v_d;
      op_q <= op_d;
      t_q  <= t_d;
    end
  end

  assign v_o  = v_q;
  assign op_o = op_q;
  assign t_o  = t_q;

  if (RW > 1) begin : g_rem
    logic [RW-2:0] rem_q, rem_d;

    // drop the input consumed here, keep the rest
    always_comb begin
      rem_d = rem_q;
      if (ld) rem_d = rem_i[RW-1:1];
    end

    // remaining-input register
    always_ff @(posedge clk) begin
      if (rst) rem_q <= '0;
      else     rem_q <= rem_d;
    end

    assign rem_o = rem_q;
  end else begin : g_last
    assign rem_o = 1'b0;
  end

`ifdef GATE_CHAIN_TAPS_EN
  logic [N-2:0] taps_q, taps_d;

  // bit K is always zero upstream, so OR inserts t[K]
  always_comb begin
    taps_d = taps_q;
    if (ld) taps_d = taps_i | (TW'(t_new) << K);
  end

  // tap register
  always_ff @(posedge clk) begin
    if (rst) taps_q <= '0;
    else     taps_q <= taps_d;
  end

  assign taps_o = taps_q;
`endif

endmodule

// File: rtl/gate_chain_pipe.sv
// gate_chain_pipe: N-1 stage pipelined gate chain with global stall.
// Define GATE_CHAIN_TAPS_EN to expose registered taps on out_taps.
module gate_chain_pipe
  import gate_chain_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  gate_chain_if.slave  io
);

  localparam int L = N - 2;

  logic adv;
  logic rdy;
  logic last_v;
  logic xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar k = 0; k < N - 1; k++) begin : g_st
    localparam int RW = N - 1 - k;
    localparam int OW = (RW > 1) ? RW - 1 : 1;

    logic          v_i, v_o;
    op_e           op_i, op_o;
    logic          t_i, t_o;
    logic [RW-1:0] rem_i;
    logic [OW-1:0] rem_o;
`ifdef GATE_CHAIN_TAPS_EN
    logic [N-2:0]  taps_i, taps_o;
`endif

    if (k == 0) begin : g_head
      assign v_i   = io.in_valid && rdy;
      assign op_i  = io.in_op;
      assign t_i   = io.in_data[0];
      assign rem_i = io.in_data[N-1:1];
`ifdef GATE_CHAIN_TAPS_EN
      assign taps_i = '0;
`endif
    end else begin : g_body
      assign v_i   = g_st[k-1].v_o;
      assign op_i  = g_st[k-1].op_o;
      assign t_i   = g_st[k-1].t_o;
      assign rem_i = g_st[k-1].rem_o;
`ifdef GATE_CHAIN_TAPS_EN
      assign taps_i = g_st[k-1].taps_o;
`endif
    end

    gate_chain_stage #(
      .N  (N),
      .K  (k),
      .RW (RW)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .adv   (adv),
      .v_i   (v_i),
      .op_i  (op_i),
      .t_i   (t_i),
      .rem_i (rem_i),
`ifdef GATE_CHAIN_TAPS_EN
      .taps_i(taps_i),
      .taps_o(taps_o),
`endif
      .v_o   (v_o),
      .op_o  (op_o),
      .t_o   (t_o),
      .rem_o (rem_o)
    );
  end

  logic tail_unused;
  assign tail_unused = ^{g_st[L].op_o, g_st[L].rem_o};

  assign last_v = g_st[L].v_o;
  assign adv    = io.out_ready || !last_v;
  assign rdy    = adv && !rst;
  assign xfer   = last_v && io.out_ready;

  // delivered-result counter, wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign io.in_ready   = rdy;
  assign io.out_valid  = last_v;
  assign io.out_result = g_st[L].t_o;
  assign io.out_count  = cnt_q;
`ifdef GATE_CHAIN_TAPS_EN
  assign io.out_taps   = g_st[L].taps_o;
`endif

endmodule

// File: tb/tb_gate_chain_pipe.sv
// tb_gate_chain_pipe: directed vectors for gate_chain_pipe (N=4),
// one CNT_W=16 and one CNT_W=4 instance sharing the same stimulus.
module tb_gate_chain_pipe;
  import gate_chain_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv;
  logic       ordy;
  logic [3:0] id;
  op_e        iop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_chain_if #(.N(4), .CNT_W(16)) b16();
  gate_chain_if #(.N(4), .CNT_W(4))  b4();

  assign b16.in_valid  = iv;
  assign b16.in_data   = id;
  assign b16.in_op     = iop;
  assign b16.out_ready = ordy;
  assign b4.in_valid   = iv;
  assign b4.in_data    = id;
  assign b4.in_op      = iop;
  assign b4.out_ready  = ordy;

  gate_chain_pipe #(.N(4), .CNT_W(16)) u_dut (
    .clk(clk),
    .rst(rst),
    .io (b16.slave)
  );

  gate_chain_pipe #(.N(4), .CNT_W(4)) u_dut4 (
    .clk(clk),
    .rst(rst),
    .io (b4.slave)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
  endtask

  op_e        ops [4] = '{OP_NOR, OP_NAND, OP_XOR, OP_XNOR};
  logic [2:0] etap[4] = '{3'b010, 3'b011, 3'b011, 3'b110};
  logic       eres[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] cd  [3] = '{4'b0000, 4'b1010, 4'b1010};
  op_e        co  [3] = '{OP_NOR, OP_NOR, OP_XNOR};
  logic [2:0] ctap[3] = '{3'b101, 3'b010, 3'b110};
  logic       cres[3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b1;
    id   = 4'b0000;
    iop  = OP_NOR;
    cyc();
    cyc();

    // reset state
    check("rst_in_ready", 32'(b16.in_ready), 32'd0);
    check("rst_valid", 32'(b16.out_valid), 32'd0);
    check("rst_result", 32'(b16.out_result), 32'd0);
    check("rst_count", 32'(b16.out_count), 32'd0);
    check("rst_count4", 32'(b4.out_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(b16.in_ready), 32'd1);

    // single NOR beat on 0000
    iv  = 1'b1;
    id  = 4'b0000;
    iop = OP_NOR;
    cyc();
    iv = 1'b0;
    cyc();
    check("a_early", 32'(b16.out_valid), 32'd0);
    cyc();
    check("a_valid", 32'(b16.out_valid), 32'd1);
    check("a_result", 32'(b16.out_result), 32'd1);
`ifdef GATE_CHAIN_TAPS_EN
    check("a_taps", 32'(b16.out_taps), 32'h5);
`endif
    cyc();
    check("a_drain", 32'(b16.out_valid), 32'd0);
    check("a_count", 32'(b16.out_count), 32'd1);

    // four ops back to back on 1010
    do_reset();
    for (int c = 0; c < 8; c++) begin
      iv  = (c < 4);
      id  = 4'b1010;
      iop = ops[c % 4];
      cyc();
      if (c + 1 >= 3 && c + 1 <= 6) begin
        check($sformatf("b_valid%0d", c + 1),
              32'(b16.out_valid), 32'd1);
        check($sformatf("b_res%0d", c + 1),
              32'(b16.out_result), 32'(eres[c - 2]));
`ifdef GATE_CHAIN_TAPS_EN
        check($sformatf("b_taps%0d", c + 1),
              32'(b16.out_taps), 32'(etap[c - 2]));
`endif
      end else begin
        check($sformatf("b_idle%0d", c + 1),
              32'(b16.out_valid), 32'd0);
      end
    end
    check("b_count", 32'(b16.out_count), 32'd4);
    check("b_count4", 32'(b4.out_count), 32'd4);

    // fill, stall five cycles with a beat held upstream, release
    do_reset();
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv  = 1'b1;
      id  = cd[i];
      iop = co[i];
      cyc();
    end
    id  = 4'b1010;
    iop = OP_XOR;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("c_ready%0d", s), 32'(b16.in_ready), 32'd0);
      check($sformatf("c_valid%0d", s), 32'(b16.out_valid), 32'd1);
      check($sformatf("c_hold%0d", s), 32'(b16.out_result), 32'd1);
`ifdef GATE_CHAIN_TAPS_EN
      check($sformatf("c_htap%0d", s), 32'(b16.out_taps), 32'h5);
`endif
      cyc();
    end
    ordy = 1'b1;
    iv   = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("c_ov%0d", i), 32'(b16.out_valid), 32'd1);
      check($sformatf("c_res%0d", i),
            32'(b16.out_result), 32'(cres[i]));
`ifdef GATE_CHAIN_TAPS_EN
      check($sformatf("c_tap%0d", i),
            32'(b16.out_taps), 32'(ctap[i]));
`endif
      cyc();
    end
    check("c_empty", 32'(b16.out_valid), 32'd0);
    check("c_count", 32'(b16.out_count), 32'd3);

    // 17 transfers: 16-bit counter reads 17, 4-bit wraps to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      iv  = 1'b1;
      id  = 4'(i);
      iop = OP_XOR;
      cyc();
    end
    iv = 1'b0;
    cyc();
    cyc();
    cyc();
    check("d_count16", 32'(b16.out_count), 32'd17);
    check("d_count4", 32'(b4.out_count), 32'd1);

    // reset mid-flight discards two accepted beats
    do_reset();
    iv  = 1'b1;
    id  = 4'b0000;
    iop = OP_NOR;
    cyc();
    cyc();
    rst = 1'b1;
    iv  = 1'b0;
    #1;
    check("e_rst_ready", 32'(b16.in_ready), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("e_valid%0d", i), 32'(b16.out_valid), 32'd0);
      cyc();
    end
    check("e_count", 32'(b16.out_count), 32'd0);
    check("e_count4", 32'(b4.out_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
